microcode_sequencer: RTL and testbench
======================================

# microcode_sequencer

Steps the CPU register/bus datapath through micro-programs stored in a synchronous micro-ROM. It accepts a micro-program entry address from the opcode decoder and fetches one microword at a time. It then drives the datapath's cycle phase and its bus-input, bus-output and post-increment selectors for that microword, and reports completion back to the decoder. It sits between the decoder and the register file. All of its stepping is gated by the CPU clock enable.

## Interface
- `UADDR_W`, 8: micro-ROM address width.
- `SEL_W`, 5: width of the `reg_type` selector fields.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: CPU step enable. State advances only on `clk` edges where this is 1.
- `start_valid` in 1: decoder requests a micro-program.
- `start_addr` in `UADDR_W`: entry microword address.
- `start_ready` out 1: sequencer can accept a start.
- `busy` out 1: a micro-program is in progress.
- `done` out 1: one-`clk` pulse when the last microword completes.
- `rom_addr` out `UADDR_W`: micro-ROM address (registered).
- `rom_data` in 16: micro-ROM word, valid 1 `clk` after `rom_addr` changes.
- `alu_zero` in 1: ALU zero result, used for conditional skip.
- `current_cycle` out 2: `microcode_cycle` phase: `CYCLE_NONE`, `CYCLE_REG_FETCH` or `CYCLE_REG_WRITE`.
- `bus_input_selector` out `SEL_W`: `reg_type` source selector.
- `bus_output_selector` out `SEL_W`: `reg_type` destination selector.
- `increment_selector` out 2: `reg_inc_type` post-increment selector.

## Operation
- Microword layout:
  - [15] LAST.
  - [14:10] input selector.
  - [9:5] output selector.
  - [4:3] increment selector.
  - [2] SKIP_IF_ZERO.
  - [1:0] reserved, ignored.
- States are IDLE, LOAD, FETCH and WRITE. Every transition requires `clk_en`=1.
- IDLE:
  - `start_ready`=1.
  - On `start_valid`&`clk_en`: `upc` and `rom_addr` take `start_addr`; go to LOAD.
- LOAD:
  - `current_cycle`=`CYCLE_NONE`.
  - Go to FETCH.
- FETCH:
  - `current_cycle`=`CYCLE_REG_FETCH`.
  - Selectors decoded combinationally from `rom_data`.
  - Go to WRITE.
- WRITE:
  - `current_cycle`=`CYCLE_REG_WRITE`.
  - Selectors are decoded from `rom_data`, as in FETCH.
  - If LAST: pulse `done`, go to IDLE.
  - If not LAST and SKIP_IF_ZERO=1 and `alu_zero`=1: `upc`+=2, go to LOAD.
  - Otherwise: `upc`+=1, go to LOAD.
  - `alu_zero` is sampled on the WRITE exit edge.
- `rom_addr` equals `upc` and is held constant from LOAD through WRITE.
- Outside FETCH/WRITE, all selectors are driven to 0 and `current_cycle`=`CYCLE_NONE`.
- `upc` arithmetic is modulo 2^`UADDR_W`: 0xFF+1 gives 0x00, and 0xFE+2 gives 0x00.
- SKIP_IF_ZERO is ignored on a LAST word.
- `busy`=1 in every state except IDLE.
- `start_valid` seen outside an accepting step is ignored. It is not queued.

## Timing
- Reset values:
  - state IDLE, `upc`=0 and `rom_addr`=0.
  - `start_ready`=1, `busy`=0 and `done`=0.
  - `current_cycle`=`CYCLE_NONE`; all selectors 0.
- Asserting `reset_n` low mid-program aborts at once with the outputs above. No `done` is produced.
- With `clk_en` held at 1:
  - A microword takes 3 `clk` (LOAD, FETCH, WRITE).
  - An N-word program is busy for 3N `clk`.
  - `done` is high the `clk` after the last WRITE.
- With sparse `clk_en`, each state persists until the next enabled edge.
- `done` is exactly one `clk` wide regardless of `clk_en`.
- ROM latency is 1 `clk`. `rom_data` is valid from the first FETCH edge onward, because LOAD consumes the latency.
- The register file latches memory writes on FETCH and register writes on WRITE. The sequencer guarantees selectors are stable across both phases of a microword.

## Configuration
- `MICROCODE_CHAIN_EN`, when defined:
  - `start_ready` is also 1 during the WRITE of a LAST word.
  - A start accepted there loads `start_addr` and goes directly to LOAD, pulsing `done` on the same edge. There is no IDLE step between programs.
- When undefined: `start_ready` is 1 only in IDLE, so at least one IDLE step separates programs.

## Test plan
- Basic run: start 0x10, word 0x10 not LAST, word 0x11 LAST, `clk_en`=1.
  - `current_cycle` runs NONE, FETCH, WRITE, NONE, FETCH, WRITE.
  - `rom_addr` is 0x10 then 0x11.
  - `busy` is high for 6 `clk`; `done` pulses once, 1 `clk` after the second WRITE.
- Conditional skip: word 0x20 has SKIP_IF_ZERO=1, not LAST.
  - With `alu_zero`=1 at WRITE, the next `rom_addr` is 0x22.
  - With `alu_zero`=0, the next `rom_addr` is 0x21.
- Wrap-around:
  - Start 0xFF, not LAST: the next `rom_addr` is 0x00.
  - Start 0xFE with the skip taken: the next `rom_addr` is 0x00.
- Clock enable: `clk_en` high every 4th `clk`.
  - Each state holds for 4 `clk`.
  - `start_valid` pulsed for 1 `clk` with `clk_en`=0 is not accepted; `busy` stays 0.
  - `done` is still 1 `clk` wide.
- Reset mid-program: assert `reset_n` low during FETCH of word 0x31.
  - Immediately: `busy`=0, `current_cycle`=`CYCLE_NONE`, all selectors 0, no `done`.
  - After release: `start_ready`=1 and a new start at 0x40 runs normally.
- Chaining: `start_valid` with `start_addr` 0x50 held during the LAST WRITE of the current program.
  - With `MICROCODE_CHAIN_EN`: the next edge enters LOAD with `rom_addr`=0x50, and `done` pulses on that same edge.
  - Without it: one IDLE step occurs, then LOAD at 0x50.

Source files
------------

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: steps the datapath through micro-ROM programs, one LOAD/FETCH/WRITE triple per microword.
// Define MICROCODE_CHAIN_EN to let a new start be taken during the WRITE of a LAST word.
module microcode_sequencer #(
  parameter int UADDR_W = 8,
  parameter int SEL_W   = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               start_valid,
  input  logic [UADDR_W-1:0] start_addr,
  output logic               start_ready,
  output logic               busy,
  output logic               done,
  output logic [UADDR_W-1:0] rom_addr,
  input  logic [15:0]        rom_data,
  input  logic               alu_zero,
  output logic [1:0]         current_cycle,
  output logic [SEL_W-1:0]   bus_input_selector,
  output logic [SEL_W-1:0]   bus_output_selector,
  output logic [1:0]         increment_selector
);
  typedef enum logic [1:0] {IDLE, LOAD, FETCH, WRITE} state_t;
  localparam logic [1:0] CYCLE_NONE = 2'd0, CYCLE_REG_FETCH = 2'd1, CYCLE_REG_WRITE = 2'd2;
  state_t state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic done_q, done_d;
  logic last, active, accept, unused_rsvd;
  assign last = rom_data[15];
  assign unused_rsvd = ^rom_data[1:0];
  assign active = state_q == FETCH || state_q == WRITE;
`ifdef MICROCODE_CHAIN_EN
  assign start_ready = state_q == IDLE || (state_q == WRITE && last);
`else
  assign start_ready = state_q == IDLE;
`endif
  assign accept = clk_en && start_valid && start_ready;
  always_comb begin
    state_d = state_q;
    upc_d = upc_q;
    if (accept) begin
      state_d = LOAD;
      upc_d = start_addr;
    end else if (clk_en) begin
      case (state_q)
        LOAD:    state_d = FETCH;
        FETCH:   state_d = WRITE;
        WRITE: begin
          state_d = last ? IDLE : LOAD;
          upc_d = last ? upc_q : upc_q + UADDR_W'((rom_data[2] && alu_zero) ? 2 : 1);
        end
        default: state_d = state_q;
      endcase
    end
    done_d = clk_en && state_q == WRITE && last;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      upc_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q <= upc_d;
      done_q <= done_d;
    end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign rom_addr = upc_q;
  assign current_cycle = state_q == FETCH ? CYCLE_REG_FETCH : state_q == WRITE ? CYCLE_REG_WRITE : CYCLE_NONE;
  assign bus_input_selector = active ? SEL_W'(rom_data[14:10]) : '0;
  assign bus_output_selector = active ? SEL_W'(rom_data[9:5]) : '0;
  assign increment_selector = active ? rom_data[4:3] : 2'd0;
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: table-driven directed checks plus hand sequences for clk_en, reset abort and chaining.
module tb_microcode_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, clk_en = 1'b1, start_valid = 1'b0, alu_zero = 1'b0;
  logic [7:0] start_addr = 8'h00, rom_addr;
  logic start_ready, busy, done;
  logic [15:0] rom_data = 16'h0;
  logic [1:0] current_cycle, increment_selector;
  logic [4:0] bus_input_selector, bus_output_selector;
  logic [15:0] rom [256];
  typedef struct packed {
    logic busy; logic done; logic rdy; logic [1:0] cyc; logic [7:0] ra;
    logic [4:0] is; logic [4:0] os; logic [1:0] inc;
  } out_t;
  typedef struct packed {logic sv; logic [7:0] sa; logic az; out_t e;} vec_t;
  vec_t vecs[$];
  int n_cmp = 0, n_bad = 0;
  localparam logic T = 1'b1, F = 1'b0;
  localparam logic [1:0] CN = 2'd0, CF = 2'd1, CW = 2'd2;
`ifdef MICROCODE_CHAIN_EN
  localparam logic CH = 1'b1;
`else
  localparam logic CH = 1'b0;
`endif

  microcode_sequencer dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start_valid(start_valid),
    .start_addr(start_addr), .start_ready(start_ready), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .alu_zero(alu_zero),
    .current_cycle(current_cycle), .bus_input_selector(bus_input_selector),
    .bus_output_selector(bus_output_selector), .increment_selector(increment_selector)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmp_out(input string nm, input out_t e);
    out_t a;
    a = {busy, done, start_ready, current_cycle, rom_addr, bus_input_selector, bus_output_selector, increment_selector};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got busy=%b done=%b rdy=%b cyc=%0d rom_addr=%h in=%0d out=%0d inc=%0d; want busy=%b done=%b rdy=%b cyc=%0d rom_addr=%h in=%0d out=%0d inc=%0d",
        nm, a.busy, a.done, a.rdy, a.cyc, a.ra, a.is, a.os, a.inc, e.busy, e.done, e.rdy, e.cyc, e.ra, e.is, e.os, e.inc);
    end
  endtask

  task automatic add(input logic sv, input logic [7:0] sa, input logic az, input logic b, input logic d,
                     input logic [1:0] c, input logic [7:0] ra, input logic [4:0] is, input logic [4:0] os,
                     input logic [1:0] inc, input logic r);
    vec_t v;
    v.sv = sv; v.sa = sa; v.az = az;
    v.e = {b, d, r, c, ra, is, os, inc};
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h10] = 16'h0C88; rom[8'h11] = 16'h94D0;
    rom[8'h20] = 16'h0444; rom[8'h21] = 16'h9C04; rom[8'h22] = 16'hA003;
    rom[8'hFF] = 16'h2400; rom[8'h00] = 16'hA800; rom[8'hFE] = 16'h2C04;
    rom[8'h30] = 16'h0400; rom[8'h31] = 16'hB060; rom[8'h40] = 16'hB400; rom[8'h50] = 16'hB800;
    // sv, sa, az | busy, done, cyc, rom_addr, in, out, inc, ready
    add(T, 8'h10, F, T, F, CN, 8'h10, 5'd0, 5'd0, 2'd0, F);
    add(T, 8'h55, F, T, F, CF, 8'h10, 5'd3, 5'd4, 2'd1, F);
    add(F, 8'h00, F, T, F, CW, 8'h10, 5'd3, 5'd4, 2'd1, F);
    add(F, 8'h00, F, T, F, CN, 8'h11, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'h11, 5'd5, 5'd6, 2'd2, F);
    add(F, 8'h00, F, T, F, CW, 8'h11, 5'd5, 5'd6, 2'd2, CH);
    add(F, 8'h00, F, F, T, CN, 8'h11, 5'd0, 5'd0, 2'd0, T);
    add(F, 8'h00, F, F, F, CN, 8'h11, 5'd0, 5'd0, 2'd0, T);
    add(T, 8'h20, F, T, F, CN, 8'h20, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'h20, 5'd1, 5'd2, 2'd0, F);
    add(F, 8'h00, F, T, F, CW, 8'h20, 5'd1, 5'd2, 2'd0, F);
    add(F, 8'h00, T, T, F, CN, 8'h22, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'h22, 5'd8, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CW, 8'h22, 5'd8, 5'd0, 2'd0, CH);
    add(F, 8'h00, F, F, T, CN, 8'h22, 5'd0, 5'd0, 2'd0, T);
    add(T, 8'h20, F, T, F, CN, 8'h20, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'h20, 5'd1, 5'd2, 2'd0, F);
    add(F, 8'h00, T, T, F, CW, 8'h20, 5'd1, 5'd2, 2'd0, F);
    add(F, 8'h00, F, T, F, CN, 8'h21, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'h21, 5'd7, 5'd0, 2'd0, F);
    add(F, 8'h00, T, T, F, CW, 8'h21, 5'd7, 5'd0, 2'd0, CH);
    add(F, 8'h00, T, F, T, CN, 8'h21, 5'd0, 5'd0, 2'd0, T);
    add(T, 8'hFF, F, T, F, CN, 8'hFF, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'hFF, 5'd9, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CW, 8'hFF, 5'd9, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CN, 8'h00, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'h00, 5'd10, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CW, 8'h00, 5'd10, 5'd0, 2'd0, CH);
    add(F, 8'h00, F, F, T, CN, 8'h00, 5'd0, 5'd0, 2'd0, T);
    add(T, 8'hFE, F, T, F, CN, 8'hFE, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'hFE, 5'd11, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CW, 8'hFE, 5'd11, 5'd0, 2'd0, F);
    add(F, 8'h00, T, T, F, CN, 8'h00, 5'd0, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CF, 8'h00, 5'd10, 5'd0, 2'd0, F);
    add(F, 8'h00, F, T, F, CW, 8'h00, 5'd10, 5'd0, 2'd0, CH);
    add(F, 8'h00, F, F, T, CN, 8'h00, 5'd0, 5'd0, 2'd0, T);

    @(negedge clk);
    cmp_out("reset", {F, F, T, CN, 8'h00, 5'd0, 5'd0, 2'd0});
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      start_valid = vecs[i].sv; start_addr = vecs[i].sa; alu_zero = vecs[i].az;
      tick();
      cmp_out($sformatf("vec%0d", i), vecs[i].e);
    end
    start_valid = 1'b0; alu_zero = 1'b0;

    // sparse clk_en: a start without enable is dropped, then each state holds four clocks
    clk_en = 1'b0; start_valid = 1'b1; start_addr = 8'h10;
    tick();
    cmp_out("en_gated_start", {F, F, T, CN, 8'h00, 5'd0, 5'd0, 2'd0});
    for (int k = 0; k < 28; k++) begin
      clk_en = (k % 4 == 0); start_valid = (k == 0);
      tick();
      e = '0;
      e.busy = k < 24;
      e.done = k == 24;
      e.rdy = k >= 24 || (CH && k / 4 == 5);
      e.ra = k < 12 ? 8'h10 : 8'h11;
      e.cyc = k < 24 ? 2'((k / 4) % 3) : CN;
      if (e.cyc != CN) begin
        e.is = k < 12 ? 5'd3 : 5'd5;
        e.os = k < 12 ? 5'd4 : 5'd6;
        e.inc = k < 12 ? 2'd1 : 2'd2;
      end
      cmp_out($sformatf("en_k%0d", k), e);
    end
    clk_en = 1'b1; start_valid = 1'b0;

    // reset asserted during FETCH of word 0x31
    start_valid = 1'b1; start_addr = 8'h30;
    tick();
    cmp_out("rst_load30", {T, F, F, CN, 8'h30, 5'd0, 5'd0, 2'd0});
    start_valid = 1'b0;
    tick(); tick(); tick(); tick();
    cmp_out("rst_fetch31", {T, F, F, CF, 8'h31, 5'd12, 5'd3, 2'd0});
    reset_n = 1'b0;
    #1;
    cmp_out("rst_abort", {F, F, T, CN, 8'h00, 5'd0, 5'd0, 2'd0});
    tick();
    cmp_out("rst_hold", {F, F, T, CN, 8'h00, 5'd0, 5'd0, 2'd0});
    reset_n = 1'b1; start_valid = 1'b1; start_addr = 8'h40;
    tick();
    cmp_out("rst_load40", {T, F, F, CN, 8'h40, 5'd0, 5'd0, 2'd0});
    start_valid = 1'b0;
    tick();
    cmp_out("rst_fetch40", {T, F, F, CF, 8'h40, 5'd13, 5'd0, 2'd0});
    tick();
    cmp_out("rst_write40", {T, F, CH, CW, 8'h40, 5'd13, 5'd0, 2'd0});
    tick();
    cmp_out("rst_done40", {F, T, T, CN, 8'h40, 5'd0, 5'd0, 2'd0});

    // start held through the LAST WRITE of a one-word program
    start_valid = 1'b1; start_addr = 8'h11;
    tick();
    start_valid = 1'b0;
    tick();
    cmp_out("ch_fetch11", {T, F, F, CF, 8'h11, 5'd5, 5'd6, 2'd2});
    tick();
    cmp_out("ch_write11", {T, F, CH, CW, 8'h11, 5'd5, 5'd6, 2'd2});
    start_valid = 1'b1; start_addr = 8'h50;
    tick();
`ifdef MICROCODE_CHAIN_EN
    cmp_out("ch_load50", {T, T, F, CN, 8'h50, 5'd0, 5'd0, 2'd0});
`else
    cmp_out("ch_idle", {F, T, T, CN, 8'h11, 5'd0, 5'd0, 2'd0});
    tick();
    cmp_out("ch_load50", {T, F, F, CN, 8'h50, 5'd0, 5'd0, 2'd0});
`endif
    start_valid = 1'b0;
    tick();
    cmp_out("ch_fetch50", {T, F, F, CF, 8'h50, 5'd14, 5'd0, 2'd0});
    tick();
    cmp_out("ch_write50", {T, F, CH, CW, 8'h50, 5'd14, 5'd0, 2'd0});
    tick();
    cmp_out("ch_done50", {F, T, T, CN, 8'h50, 5'd0, 5'd0, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
